// File: rtl/pu_pkg.sv
// Shared types for the protection-unit violation logger.
//   TS_W        : width of the free-running timestamp.
//   DROP_W      : width of the saturating drop counter.
//   irq_state_t : states of the interrupt FSM.
//   log_entry_t : fixed-width part of a log entry.
//   sat_inc     : saturating increment for the drop counter.
// The full FIFO word is {addr, id, log_entry_t}. The address and ID widths
// are parameters of the logger, so they are prepended there.
package pu_pkg;

  localparam int TS_W   = 32;
  localparam int DROP_W = 16;

  typedef enum logic {
    IRQ_IDLE   = 1'b0,
    IRQ_ASSERT = 1'b1
  } irq_state_t;

  typedef struct packed {
    logic            write;
    logic [TS_W-1:0] ts;
  } log_entry_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/pu_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy count.
// Ports:
//   clk, rst : rising-edge clock and asynchronous active-high reset.
//   push, din: write request and write data.
//   pop      : read request. dout always shows the head entry.
//   push_ok  : push accepted this cycle.
//   pop_ok   : pop accepted this cycle.
//   empty, full, count : occupancy status.
// A push into a full FIFO is accepted only when a pop is accepted in the same
// cycle. A pop of an empty FIFO is ignored.
module pu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             push_ok,
  output logic             pop_ok,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // Storage has no reset: its contents are meaningless while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/violation_logger.sv
// Logs transactions that the protection unit denies.
// Each entry holds the address, the AXI ID, the direction and a timestamp.
// Ports:
//   aclk, areset        : clock and asynchronous active-high reset.
//   viol_*              : denied-transaction report. There is no back-pressure.
//   pop                 : consume the head entry.
//   clr_drop            : clear drop_cnt and overflow.
//   irq_thresh          : occupancy that raises irq. A value of 0 disables it.
//   head_*              : head entry, first-word-fall-through.
//   head_valid          : the FIFO holds at least one entry.
//   count               : current occupancy.
//   drop_cnt, overflow  : count and sticky flag for events lost while full.
//   irq                 : registered level interrupt.
import pu_pkg::*;

module violation_logger #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              viol_valid,
  input  logic              viol_write,
  input  logic [ADDR_W-1:0] viol_addr,
  input  logic [ID_W-1:0]   viol_id,
  input  logic              pop,
  input  logic              clr_drop,
  input  logic [CW-1:0]     irq_thresh,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [ID_W-1:0]   head_id,
  output logic              head_write,
  output logic [TS_W-1:0]   head_ts,
  output logic [CW-1:0]     count,
  output logic [15:0]       drop_cnt,
  output logic              overflow,
  output logic              irq
);

  localparam int ENTRY_W = ADDR_W + ID_W + $bits(log_entry_t);

  logic               armed;
  logic               push_req, pop_req, clr_req;
  logic [TS_W-1:0]    ts_q;
  log_entry_t         meta_in, meta_out;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic               push_ok, pop_ok, fifo_empty, fifo_full;
  logic               drop;
  logic [CW-1:0]      count_next;
  logic [15:0]        drop_d;
  logic               overflow_d;
  logic               irq_hold;
  irq_state_t         state_q, state_d;

  // The first edge after reset release only arms the block. This gives the
  // upstream logic one cycle to settle before its strobes are trusted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  assign push_req = viol_valid && armed;
  assign pop_req  = pop && armed;
  assign clr_req  = clr_drop && armed;

  // The timestamp runs freely and wraps at 2^32.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  always_comb begin
    meta_in       = '0;
    meta_in.write = viol_write;
    meta_in.ts    = ts_q;
  end

  assign fifo_din = {viol_addr, viol_id, meta_in};

  pu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push    (push_req),
    .din     (fifo_din),
    .pop     (pop_req),
    .dout    (fifo_dout),
    .push_ok (push_ok),
    .pop_ok  (pop_ok),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (count)
  );

  assign {head_addr, head_id, meta_out} = fifo_dout;
  assign head_write = meta_out.write;
  assign head_ts    = meta_out.ts;
  assign head_valid = !fifo_empty;

  // An event is lost only when the FIFO is full and no pop frees a slot.
  // A same-cycle clear wins over a drop.
  assign drop = push_req && fifo_full && !pop_ok;

  always_comb begin
    drop_d     = drop_cnt;
    overflow_d = overflow;
    if (clr_req) begin
      drop_d     = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      drop_d     = sat_inc(drop_cnt);
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      drop_cnt <= drop_d;
      overflow <= overflow_d;
    end
  end

  // The irq decision uses the next occupancy and the next overflow value.
  // This makes irq change on the same edge as count and overflow.
  assign count_next = count + CW'(push_ok) - CW'(pop_ok);
  assign irq_hold   = overflow_d || ((irq_thresh != '0) && (count_next >= irq_thresh));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IRQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE:   if (irq_hold)  state_d = IRQ_ASSERT;
      IRQ_ASSERT: if (!irq_hold) state_d = IRQ_IDLE;
      default:    state_d = IRQ_IDLE;
    endcase
  end

  // irq is decoded from a single state flop, so it cannot glitch.
  assign irq = (state_q == IRQ_ASSERT);

endmodule

// File: tb/tb_violation_logger.sv
// Self-checking bench for violation_logger.
// Accepted events are queued with the timestamp expected at capture time.
// Each accepted pop checks the DUT head against the front of that queue.
// Occupancy, drop count, overflow and irq are checked against a small model.
module tb_violation_logger;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          aclk = 1'b0;
  logic          areset;
  logic          viol_valid, viol_write, pop, clr_drop;
  logic [31:0]   viol_addr;
  logic [3:0]    viol_id;
  logic [CW-1:0] irq_thresh;
  logic          head_valid, head_write, overflow, irq;
  logic [31:0]   head_addr, head_ts;
  logic [3:0]    head_id;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic        write;
    logic [31:0] ts;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_drop = '0;
  bit          m_ovf = 0;
  bit          m_irq = 0;
  logic [31:0] tb_ts;

  violation_logger #(.DEPTH(DEPTH), .ADDR_W(32), .ID_W(4)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .viol_valid (viol_valid),
    .viol_write (viol_write),
    .viol_addr  (viol_addr),
    .viol_id    (viol_id),
    .pop        (pop),
    .clr_drop   (clr_drop),
    .irq_thresh (irq_thresh),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_id    (head_id),
    .head_write (head_write),
    .head_ts    (head_ts),
    .count      (count),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow),
    .irq        (irq)
  );

  always #5 aclk = ~aclk;

  // Reference timestamp: cycles elapsed since the last reset.
  always @(posedge aclk or posedge areset) begin
    if (areset) tb_ts <= '0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  // Runs one clock cycle. On an accepted pop it checks the head against the
  // scoreboard, then it updates the scoreboard and the status model.
  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [3:0] id, input logic p, input logic clr);
    exp_t e;
    bit   full_pre, empty_pre, pop_acc, push_acc;
    @(negedge aclk);
    full_pre  = (sb.size() == DEPTH);
    empty_pre = (sb.size() == 0);
    pop_acc   = p && !empty_pre;
    push_acc  = v && (!full_pre || pop_acc);
    if (pop_acc) begin
      e = sb.pop_front();
      vectors++;
      if (head_valid !== 1'b1 || head_addr !== e.addr || head_id !== e.id ||
          head_write !== e.write || head_ts !== e.ts) begin
        miscompares++;
        $display("[TB] FAIL pop_head: got v=%b addr=%h id=%h w=%b ts=%0d, want v=1 addr=%h id=%h w=%b ts=%0d",
                 head_valid, head_addr, head_id, head_write, head_ts, e.addr, e.id, e.write, e.ts);
      end
    end
    if (push_acc) sb.push_back('{a, id, w, tb_ts});
    if (clr) begin
      m_drop = '0;
      m_ovf  = 0;
    end else if (v && !push_acc) begin
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      m_ovf = 1;
    end
    viol_valid = v; viol_write = w; viol_addr = a; viol_id = id; pop = p; clr_drop = clr;
    @(posedge aclk);
    #1;
    viol_valid = 0; viol_write = 0; viol_addr = '0; viol_id = '0; pop = 0; clr_drop = 0;
    m_irq = m_ovf || (irq_thresh != 0 && sb.size() >= int'(irq_thresh));
  endtask

  task automatic test_reset();
    areset = 1; viol_valid = 0; viol_write = 0; viol_addr = '0; viol_id = '0;
    pop = 0; clr_drop = 0; irq_thresh = '0;
    repeat (2) @(posedge aclk);
    #1;
    vectors++; if (count !== '0) begin miscompares++; $display("[TB] FAIL rst_count: got %0d, want 0", count); end
    vectors++; if (head_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_head_valid: got %b, want 0", head_valid); end
    vectors++; if (drop_cnt !== '0) begin miscompares++; $display("[TB] FAIL rst_drop: got %0d, want 0", drop_cnt); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_overflow: got %b, want 0", overflow); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_irq: got %b, want 0", irq); end
    // Strobes on the first edge after release must have no effect.
    @(negedge aclk);
    areset = 0; viol_valid = 1; viol_addr = 32'hDEAD_BEEF; clr_drop = 1; pop = 1;
    @(posedge aclk);
    #1;
    viol_valid = 0; viol_addr = '0; clr_drop = 0; pop = 0;
    vectors++; if (count !== '0) begin miscompares++; $display("[TB] FAIL release_ignore_count: got %0d, want 0", count); end
    vectors++; if (head_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL release_ignore_valid: got %b, want 0", head_valid); end
  endtask

  task automatic test_single();
    int guard = 0;
    while (tb_ts != 32'd5 && guard < 20) begin
      step(0, 0, '0, '0, 0, 0);
      guard++;
    end
    vectors++;
    if (tb_ts != 32'd5) begin miscompares++; $display("[TB] FAIL ts_wait: got %0d, want 5", tb_ts); end
    step(1, 1, 32'h4000_0010, 4'd3, 0, 0);
    vectors++;
    if (head_valid !== 1'b1 || head_addr !== 32'h4000_0010 || head_id !== 4'd3 ||
        head_write !== 1'b1 || head_ts !== 32'd5 || count !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL single_capture: got v=%b addr=%h id=%0d w=%b ts=%0d cnt=%0d, want 1 40000010 3 1 5 1",
               head_valid, head_addr, head_id, head_write, head_ts, count);
    end
    step(0, 0, '0, '0, 1, 0);
    vectors++; if (count !== '0) begin miscompares++; $display("[TB] FAIL single_pop_count: got %0d, want 0", count); end
  endtask

  task automatic test_overflow();
    irq_thresh = '0;
    for (int i = 0; i < 10; i++) step(1, i[0], 32'h1000_0000 + i, 4'(i), 0, 0);
    vectors++; if (count !== 4'd8) begin miscompares++; $display("[TB] FAIL ovf_count: got %0d, want 8", count); end
    vectors++; if (drop_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL ovf_drop: got %0d, want 2", drop_cnt); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag: got %b, want 1", overflow); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_irq: got %b, want 1", irq); end
    vectors++; if (head_addr !== 32'h1000_0000) begin miscompares++; $display("[TB] FAIL ovf_head: got %h, want 10000000", head_addr); end
  endtask

  task automatic test_full_push_pop();
    step(1, 1, 32'hABCD_0000, 4'h9, 1, 0);
    vectors++; if (count !== 4'd8) begin miscompares++; $display("[TB] FAIL fpp_count: got %0d, want 8", count); end
    vectors++; if (drop_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL fpp_drop: got %0d, want 2", drop_cnt); end
    vectors++; if (head_addr !== 32'h1000_0001) begin miscompares++; $display("[TB] FAIL fpp_head: got %h, want 10000001", head_addr); end
  endtask

  task automatic test_clr_drop();
    step(1, 0, 32'h5555_0000, 4'h1, 0, 1);
    vectors++; if (drop_cnt !== m_drop) begin miscompares++; $display("[TB] FAIL clr_drop_cnt: got %0d, want %0d", drop_cnt, m_drop); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_overflow: got %b, want 0", overflow); end
    vectors++; if (irq !== m_irq) begin miscompares++; $display("[TB] FAIL clr_irq: got %b, want %b", irq, m_irq); end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("[TB] FAIL clr_count: got %0d, want 8", count); end
    for (int i = 0; i < 10 && sb.size() > 0; i++) step(0, 0, '0, '0, 1, 0);
    vectors++; if (count !== '0 || head_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_empty: got cnt=%0d v=%b, want 0 0", count, head_valid); end
  endtask

  task automatic test_empty_push_pop();
    step(1, 0, 32'h7777_0004, 4'd5, 1, 0);
    vectors++; if (count !== 4'd1 || head_addr !== 32'h7777_0004) begin miscompares++; $display("[TB] FAIL epp: got cnt=%0d addr=%h, want 1 77770004", count, head_addr); end
    step(0, 0, '0, '0, 1, 0);
    step(0, 0, '0, '0, 1, 0);
    vectors++; if (count !== '0 || head_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_pop: got cnt=%0d v=%b, want 0 0", count, head_valid); end
  endtask

  task automatic test_irq_thresh();
    irq_thresh = 4'd3;
    step(1, 0, 32'h2000_0000, 4'd1, 0, 0);
    step(1, 1, 32'h2000_0004, 4'd2, 0, 0);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_below: got %b, want 0", irq); end
    step(1, 0, 32'h2000_0008, 4'd3, 0, 0);
    vectors++; if (count !== 4'd3 || irq !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_at3: got cnt=%0d irq=%b, want 3 1", count, irq); end
    step(0, 0, '0, '0, 1, 0);
    vectors++; if (count !== 4'd2 || irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_drop: got cnt=%0d irq=%b, want 2 0", count, irq); end
    irq_thresh = 4'd2;
    step(0, 0, '0, '0, 0, 0);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_thresh_change: got %b, want 1", irq); end
    irq_thresh = 4'd0;
    step(0, 0, '0, '0, 0, 0);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_disable: got %b, want 0", irq); end
    step(0, 0, '0, '0, 1, 0);
    step(0, 0, '0, '0, 1, 0);
  endtask

  task automatic test_back_to_back();
    logic v, p;
    irq_thresh = 4'd4;
    for (int i = 0; i < 48; i++) begin
      v = ($urandom_range(0, 3) != 0);
      p = (i < 24) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      step(v, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), p, 0);
      vectors++;
      if (count !== CW'(sb.size()) || irq !== m_irq || drop_cnt !== m_drop || overflow !== m_ovf) begin
        miscompares++;
        $display("[TB] FAIL b2b_status[%0d]: got cnt=%0d irq=%b drop=%0d ovf=%b, want %0d %b %0d %b",
                 i, count, irq, drop_cnt, overflow, sb.size(), m_irq, m_drop, m_ovf);
      end
    end
    for (int i = 0; i < 12 && sb.size() > 0; i++) step(0, 0, '0, '0, 1, 0);
    vectors++; if (count !== '0) begin miscompares++; $display("[TB] FAIL b2b_drain: got %0d, want 0", count); end
  endtask

  task automatic test_reset_mid();
    step(0, 0, '0, '0, 0, 1);
    irq_thresh = 4'd3;
    for (int i = 0; i < 5; i++) step(1, 0, 32'h3000_0000 + i, 4'(i), 0, 0);
    vectors++; if (count !== 4'd5 || irq !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre: got cnt=%0d irq=%b, want 5 1", count, irq); end
    @(negedge aclk);
    #1 areset = 1;
    #1;
    vectors++; if (count !== '0) begin miscompares++; $display("[TB] FAIL mid_rst_count: got %0d, want 0", count); end
    vectors++; if (head_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_valid: got %b, want 0", head_valid); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_irq: got %b, want 0", irq); end
    sb.delete(); m_drop = '0; m_ovf = 0; m_irq = 0;
    @(negedge aclk);
    areset = 0;
    @(posedge aclk);
    #1;
    step(1, 1, 32'h6000_0000, 4'd7, 0, 0);
    step(0, 0, '0, '0, 1, 0);
    vectors++; if (count !== '0) begin miscompares++; $display("[TB] FAIL post_rst: got %0d, want 0", count); end
  endtask

  initial begin
    $display("[TB] violation_logger bench start");
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_clr_drop();
    test_empty_push_pop();
    test_irq_thresh();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/violation_logger.md
VIOLATION_LOGGER -- requirements
Module: violation_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 8, log FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter ADDR_W, default 32, width of the logged AXI address.
REQ-003 SHALL have parameter ID_W, default 4, width of the logged AXI ID.
REQ-004 SHALL have port aclk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port viol_valid  input  1  protection unit reports a denied transaction this cycle.
REQ-007 SHALL have port viol_write  input  1  1 = denied write, 0 = denied read.
REQ-008 SHALL have port viol_addr  input  ADDR_W  address of the denied transaction.
REQ-009 SHALL have port viol_id  input  ID_W  AXI ID of the denied transaction.
REQ-010 SHALL have port pop  input  1  config register block consumes the head entry (pulse).
REQ-011 SHALL have port clr_drop  input  1  clears drop counter and overflow flag (pulse).
REQ-012 SHALL have port irq_thresh  input  $clog2(DEPTH+1)  entry count that raises irq; 0 disables irq.
REQ-013 SHALL have port head_valid  output  1  FIFO non-empty.
REQ-014 SHALL have port head_addr / head_id / head_write / head_ts  output  ADDR_W / ID_W / 1 / 32  head entry fields, first-word-fall-through.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-016 SHALL have port drop_cnt  output  16  events lost while full, saturating.
REQ-017 SHALL have port overflow  output  1  sticky: at least one event dropped.
REQ-018 SHALL have port irq  output  1  level interrupt, registered.

Function
REQ-019 SHALL run a free-running 32-bit timestamp counter, +1 per cycle, wrapping 0xFFFFFFFF -> 0.
REQ-020 SHALL capture {viol_addr, viol_id, viol_write, timestamp} on the cycle viol_valid=1 and FIFO not full; never back-pressure (no ready).
REQ-021 SHALL make a pushed entry visible on head_* and count one cycle after capture.
REQ-022 SHALL, on pop with head_valid=1, advance head next cycle; pop when empty SHALL be ignored.
REQ-023 SHALL, when full and viol_valid=1 with no pop, drop the event, increment drop_cnt (saturate at 0xFFFF), set overflow.
REQ-024 SHALL, when full with simultaneous viol_valid and pop, accept push and pop; count unchanged, no drop.
REQ-025 SHALL, when empty with simultaneous viol_valid and pop, accept push, ignore pop; count becomes 1.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-027 SHALL give clr_drop priority over a same-cycle drop: result drop_cnt=0, overflow=0.
REQ-028 SHALL implement irq FSM IDLE/ASSERT: IDLE->ASSERT when irq_thresh!=0 and next count >= irq_thresh, or overflow set; ASSERT->IDLE when next count < irq_thresh and overflow=0; irq=1 only in ASSERT.
REQ-029 SHALL hold irq_thresh changes effective the following cycle, with no glitch on irq.

Reset
REQ-030 SHALL, on areset=1, asynchronously clear pointers, count=0, head_valid=0, drop_cnt=0, overflow=0, timestamp=0, irq FSM=IDLE, irq=0.
REQ-031 SHALL discard FIFO contents on reset mid-operation; head_* data values are don't-care while head_valid=0.
REQ-032 SHALL ignore viol_valid, pop, clr_drop in the first cycle after reset release; behaviour normal from the next edge.

Structure
REQ-033 SHALL place the log-entry packed struct type, the irq state enum and TS_W=32 in shared package pu_pkg.
REQ-034 SHALL use one sub-module, pu_sync_fifo (parametric width/depth, FWFT, count output); counters, drop logic and irq FSM reside in violation_logger.

Verification
REQ-035 Reset, then viol_valid one cycle with addr=0x4000_0010, id=3, write=1 at ts=5 -> next cycle head_valid=1, head_addr=0x4000_0010, head_id=3, head_write=1, head_ts=5, count=1.
REQ-036 DEPTH=8, push 10 events, no pop -> count=8, drop_cnt=2, overflow=1, irq=1; head holds the first event.
REQ-037 FIFO full, viol_valid+pop same cycle -> count stays 8, drop_cnt unchanged, new entry at tail, old head gone.
REQ-038 irq_thresh=3, push 3 events -> irq=1 the cycle after count=3; pop once -> irq=0 the cycle after count=2.
REQ-039 After overflow, clr_drop coincident with a dropped event -> drop_cnt=0, overflow=0.
REQ-040 Assert areset mid-stream with count=5 -> count=0, head_valid=0, irq=0 immediately, without a clock edge.
